// File: rtl/shop_pkg.sv
// Shared types and constants for the checkout theft-alarm controller.
// Holds the two-state FSM encoding, the counter width and the saturation limit,
// plus a saturating-increment helper used by both item counters.
package shop_pkg;

    // Alarm FSM: IDLE counts scans, ALARM locks out scanning until acknowledged.
    typedef enum logic {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } state_t;

    localparam int                 COUNT_W   = 4;
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(15);

    // Increment that sticks at COUNT_MAX instead of wrapping to zero.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for one raw button input.
// Ports: clk, reset (sync, active-high), in (raw async level), pulse (one-cycle, comb from flops).
// Latency: pulse is high in the cycle after the 2nd edge that sees in high; held levels give one pulse.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic sync1;    // first synchronizer stage (may go metastable)
    logic sync2;    // second synchronizer stage, safe to use
    logic prev;     // sync2 delayed one cycle, for edge detection
    logic fill1;    // tracks synchronizer pipeline refill after reset
    logic fill2;
    logic armed;    // set once a released (low) level has been seen after reset

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            prev  <= sync2;
            fill1 <= 1'b1;
            fill2 <= fill1;
            // The zeros left by reset are not a real release: only arm once
            // sync2 carries a genuinely sampled low level. A button held through
            // reset therefore stays silent until it is let go and pressed again.
            armed <= armed | (fill2 & ~sync2);
        end
    end

    assign pulse = armed & sync2 & ~prev;

endmodule

// File: rtl/theft_alarm_ctrl.sv
// Checkout theft alarm: counts stolen and discounted scans, raises a blinking alarm on a stolen item.
// Ports: clk, reset (sync active-high), scan/ack (raw buttons), discounted/stolen (classifier flags),
//        alarm, alarm_blink, stolen_count, discount_count. State updates 3 edges after scan is first sampled.
module theft_alarm_ctrl
    import shop_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scan,
    input  logic               ack,
    input  logic               discounted,
    input  logic               stolen,
    output logic               alarm,
    output logic               alarm_blink,
    output logic [COUNT_W-1:0] stolen_count,
    output logic [COUNT_W-1:0] discount_count
);

    localparam int              PW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_TOP = PW'(BLINK_DIV - 1);

    logic scan_pulse;
    logic ack_pulse;

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      presc;
    logic [PW-1:0]      presc_nxt;
    logic               blink_nxt;
    logic [COUNT_W-1:0] stolen_nxt;
    logic [COUNT_W-1:0] discount_nxt;

    edge_sync u_scan_sync (
        .clk   (clk),
        .reset (reset),
        .in    (scan),
        .pulse (scan_pulse)
    );

    edge_sync u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .in    (ack),
        .pulse (ack_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            presc          <= '0;
            alarm_blink    <= 1'b0;
            stolen_count   <= '0;
            discount_count <= '0;
        end else begin
            state          <= state_nxt;
            presc          <= presc_nxt;
            alarm_blink    <= blink_nxt;
            stolen_count   <= stolen_nxt;
            discount_count <= discount_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        presc_nxt    = presc;
        blink_nxt    = alarm_blink;
        stolen_nxt   = stolen_count;
        discount_nxt = discount_count;

        case (state)
            IDLE: begin
                // Blink is parked low with a cleared prescaler so every alarm
                // starts from the same phase. Ack is meaningless here.
                presc_nxt = '0;
                blink_nxt = 1'b0;
                if (scan_pulse) begin
                    if (stolen) begin
                        // Stolen takes priority over discounted: the item is
                        // counted once, as stolen, and the light comes on high.
                        state_nxt  = ALARM;
                        stolen_nxt = sat_inc(stolen_count);
                        blink_nxt  = 1'b1;
                    end else if (discounted) begin
                        discount_nxt = sat_inc(discount_count);
                    end
                end
            end

            ALARM: begin
                // Scans are locked out entirely; only the clerk's ack leaves.
                // An ack coinciding with a scan wins and the scan is lost.
                if (ack_pulse) begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                    blink_nxt = 1'b0;
                end else if (presc == PRESC_TOP) begin
                    presc_nxt = '0;
                    blink_nxt = ~alarm_blink;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign alarm = (state == ALARM);

endmodule

// File: tb/tb_theft_alarm_ctrl.sv
// Directed self-checking bench for theft_alarm_ctrl with a short blink period.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-derived from the scan-to-update timing and counting rules.
module tb_theft_alarm_ctrl;

    logic       clk;
    logic       reset;
    logic       scan;
    logic       ack;
    logic       discounted;
    logic       stolen;
    logic       alarm;
    logic       alarm_blink;
    logic [3:0] stolen_count;
    logic [3:0] discount_count;

    int total;
    int bad;

    theft_alarm_ctrl #(.BLINK_DIV(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .scan           (scan),
        .ack            (ack),
        .discounted     (discounted),
        .stolen         (stolen),
        .alarm          (alarm),
        .alarm_blink    (alarm_blink),
        .stolen_count   (stolen_count),
        .discount_count (discount_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full press/release: the state update lands inside the 4-cycle hold.
    task automatic press_scan();
        scan = 1'b1;
        tick(4);
        scan = 1'b0;
        tick(4);
    endtask

    task automatic press_ack();
        ack = 1'b1;
        tick(4);
        ack = 1'b0;
        tick(4);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        scan       = 1'b0;
        ack        = 1'b0;
        discounted = 1'b0;
        stolen     = 1'b0;

        // Reset state
        tick(3);
        chk("rst_alarm", alarm, 0);
        chk("rst_blink", alarm_blink, 0);
        chk("rst_stolen", stolen_count, 0);
        chk("rst_disc", discount_count, 0);
        reset = 1'b0;
        tick(4);

        // Stolen scan: alarm exactly on the 3rd edge after scan is sampled
        stolen     = 1'b1;
        discounted = 1'b1;
        tick(1);
        scan = 1'b1;
        tick(2);
        chk("stolen_early_alarm", alarm, 0);
        chk("stolen_early_cnt", stolen_count, 0);
        tick(1);
        chk("stolen_alarm", alarm, 1);
        chk("stolen_cnt", stolen_count, 1);
        chk("stolen_disc_unchanged", discount_count, 0);

        // Blink: 4 high, 4 low, repeating, starting high at entry
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("blink_%0d", i), alarm_blink, ((i / 4) % 2 == 0) ? 1 : 0);
            if (i == 1) scan = 1'b0;
            tick(1);
        end

        // Scans locked out in ALARM
        for (int i = 0; i < 3; i++) press_scan();
        chk("lockout_stolen", stolen_count, 1);
        chk("lockout_alarm", alarm, 1);

        // Ack leaves ALARM on the same 3-edge timing
        ack = 1'b1;
        tick(2);
        chk("ack_early_alarm", alarm, 1);
        tick(1);
        chk("ack_alarm", alarm, 0);
        chk("ack_blink", alarm_blink, 0);
        ack = 1'b0;
        tick(4);

        // Ack ignored in IDLE
        press_ack();
        chk("idle_ack_alarm", alarm, 0);
        chk("idle_ack_stolen", stolen_count, 1);

        // Scan with both flags low changes nothing
        stolen     = 1'b0;
        discounted = 1'b0;
        press_scan();
        chk("plain_disc", discount_count, 0);
        chk("plain_stolen", stolen_count, 1);
        chk("plain_alarm", alarm, 0);

        // Discounted scans count and saturate at 15
        discounted = 1'b1;
        press_scan();
        chk("disc_first", discount_count, 1);
        for (int i = 0; i < 16; i++) press_scan();
        chk("disc_sat", discount_count, 15);
        chk("disc_alarm", alarm, 0);
        chk("disc_stolen", stolen_count, 1);

        // Scan and ack rising together in ALARM: ack wins, scan dropped
        stolen = 1'b1;
        press_scan();
        chk("coin_enter_alarm", alarm, 1);
        chk("coin_enter_stolen", stolen_count, 2);
        scan = 1'b1;
        ack  = 1'b1;
        tick(4);
        chk("coin_alarm", alarm, 0);
        chk("coin_blink", alarm_blink, 0);
        chk("coin_stolen", stolen_count, 2);
        chk("coin_disc", discount_count, 15);
        tick(6);
        chk("coin_held_alarm", alarm, 0);
        chk("coin_held_stolen", stolen_count, 2);
        scan = 1'b0;
        ack  = 1'b0;
        tick(4);

        // Stolen counter saturates at 15
        for (int i = 0; i < 14; i++) begin
            press_scan();
            press_ack();
        end
        chk("stolen_sat", stolen_count, 15);
        chk("stolen_sat_alarm", alarm, 0);

        // Reset mid-ALARM with scan held through reset
        press_scan();
        chk("pre_rst_alarm", alarm, 1);
        chk("pre_rst_stolen", stolen_count, 15);
        scan = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_alarm", alarm, 0);
        chk("mid_rst_blink", alarm_blink, 0);
        chk("mid_rst_stolen", stolen_count, 0);
        chk("mid_rst_disc", discount_count, 0);
        reset = 1'b0;
        tick(10);
        chk("held_after_rst_alarm", alarm, 0);
        chk("held_after_rst_stolen", stolen_count, 0);
        scan = 1'b0;
        tick(4);
        press_scan();
        chk("repress_alarm", alarm, 1);
        chk("repress_stolen", stolen_count, 1);
        chk("repress_disc", discount_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/theft_alarm_ctrl.md
THEFT_ALARM_CTRL -- requirements
Module: theft_alarm_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25_000_000, meaning clk cycles per half-period of the alarm blink.
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port scan, input, 1, raw asynchronous active-high scan button; a rising edge means one item was scanned.
REQ-005 SHALL have port ack, input, 1, raw asynchronous active-high clerk acknowledge button.
REQ-006 SHALL have port discounted, input, 1, discounted flag from the upstream UPC classifier.
REQ-007 SHALL have port stolen, input, 1, stolen flag from the upstream UPC classifier.
REQ-008 SHALL have port alarm, output, 1, high while the FSM is in ALARM.
REQ-009 SHALL have port alarm_blink, output, 1, square wave while in ALARM; low otherwise.
REQ-010 SHALL have port stolen_count, output, 4, saturating count of stolen scans.
REQ-011 SHALL have port discount_count, output, 4, saturating count of discounted, non-stolen scans.

Function
REQ-012 SHALL pass scan and ack each through a 2-flop synchronizer, then a rising-edge detector, giving one-cycle scan_pulse and ack_pulse.
REQ-013 SHALL sample discounted and stolen in the cycle scan_pulse is high; these flags are stable for at least 4 cycles around each scan.
REQ-014 SHALL update counters and FSM state on the 3rd rising clk edge at or after the first edge that samples scan high.
REQ-015 SHALL implement FSM states IDLE and ALARM only.
REQ-016 IDLE with scan_pulse and stolen=1 SHALL go to ALARM and increment stolen_count; discount_count SHALL stay unchanged even if discounted=1.
REQ-017 IDLE with scan_pulse, stolen=0 and discounted=1 SHALL increment discount_count and stay in IDLE.
REQ-018 IDLE with scan_pulse and both flags 0 SHALL change nothing.
REQ-019 ALARM SHALL ignore scan_pulse, as a lockout with no counting.
REQ-020 ALARM with ack_pulse SHALL go to IDLE next cycle; if scan_pulse and ack_pulse coincide, ack SHALL win and the scan SHALL be dropped.
REQ-021 IDLE SHALL ignore ack_pulse.
REQ-022 Counters SHALL saturate at 15 and never wrap.
REQ-023 The blink prescaler SHALL clear on entry to ALARM and toggle alarm_blink every BLINK_DIV cycles, with the first toggle high at entry.
REQ-024 alarm_blink SHALL be forced low in IDLE.
REQ-025 A held scan or ack level SHALL produce exactly one pulse; the next pulse requires a release seen low after synchronization.

Reset
REQ-026 While reset is high at a clk edge, SHALL set the FSM to IDLE, alarm=0, alarm_blink=0, both counts=0, prescaler=0, and synchronizer and edge flops=0.
REQ-027 Reset asserted mid-ALARM SHALL return to IDLE with counters cleared at that same edge.
REQ-028 A button already held when reset releases SHALL produce no pulse until it is released and pressed again.

Structure
REQ-029 Package shop_pkg SHALL hold the state enum (IDLE, ALARM), COUNT_W=4 and COUNT_MAX=15.
REQ-030 Sub-module edge_sync SHALL implement one synchronizer plus rising-edge detector with ports clk, reset, in, pulse, and SHALL be instantiated twice.
REQ-031 The top-level shall map outputs as: alarm to LEDR[9], alarm_blink to LEDR[8], counts to HEX decoders; this mapping is outside this module.

Verification
REQ-032 Reset, then scan with stolen=1 -> alarm=1 and stolen_count=1 exactly 3 edges after scan is sampled; discount_count=0.
REQ-033 In IDLE, 17 scans with discounted=1, stolen=0 -> discount_count=15, alarm=0.
REQ-034 In ALARM, 3 scans with stolen=1, then ack -> stolen_count stays 1, then alarm=0 and alarm_blink=0.
REQ-035 With BLINK_DIV=4 in ALARM -> alarm_blink high 4 cycles, low 4 cycles, repeating.
REQ-036 scan and ack rise in the same cycle during ALARM -> IDLE, counts unchanged; reset pulse during ALARM -> all outputs 0 next cycle.
